// File: rtl/run_step_ctrl.sv
// rtl/run_step_ctrl.sv - run/step execution sequencer with debounced buttons and saturating cycle/instruction counters

module run_step_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic raw,
    output logic pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          accept;

    // cnt tracks how many consecutive synchronised samples disagreed with the accepted level
    assign accept = (sync2 != level) && (cnt == LAST);
    assign pulse  = accept && sync2;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module run_step_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [4:0] FETCH_STATE     = 5'd0,
    parameter int         CNT_W           = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic             mode_sw,
    input  logic [4:0]       CurrentState,
    input  logic             endProgram,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_t;

    state_t state;
    logic   run_p;
    logic   step_p;
    logic   stop_pend;
    logic   left_fetch;
    logic   boundary;

    run_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .CLK   (CLK),
        .RESET (RESET),
        .raw   (run_btn),
        .pulse (run_p)
    );

    run_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .CLK   (CLK),
        .RESET (RESET),
        .raw   (step_btn),
        .pulse (step_p)
    );

    assign boundary = (CurrentState == FETCH_STATE);

    // Enable is withheld at the fetch boundary so a pause or step always stops before a new instruction
    always_comb begin
        cpu_en = 1'b0;
        if (!RESET) begin
            case (state)
                RUN:     cpu_en = !endProgram && !(stop_pend && boundary);
                STEP:    cpu_en = !endProgram && !(left_fetch && boundary);
                default: cpu_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            stop_pend  <= 1'b0;
            left_fetch <= 1'b0;
            running    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            running <= (state == RUN);
            halted  <= (state == HALT);
            case (state)
                IDLE: begin
                    if (step_p) begin
                        state      <= STEP;
                        left_fetch <= 1'b0;
                    end else if (run_p && mode_sw) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (endProgram) begin
                        state     <= HALT;
                        stop_pend <= 1'b0;
                    end else if (stop_pend && boundary) begin
                        state     <= IDLE;
                        stop_pend <= 1'b0;
                    end else if (run_p || !mode_sw) begin
                        stop_pend <= 1'b1;
                    end
                end
                STEP: begin
                    if (endProgram) begin
                        state <= HALT;
                    end else if (left_fetch && boundary) begin
                        state <= IDLE;
                    end else if (cpu_en) begin
                        left_fetch <= 1'b1;
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else if (cpu_en) begin
            if (cycle_count != '1) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (boundary && (instr_count != '1)) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_run_step_ctrl.sv
// tb/tb_run_step_ctrl.sv - self-checking bench for run_step_ctrl

module tb_run_step_ctrl;
    localparam int DB     = 16;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_HALT = 3;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        run_btn = 1'b0;
    logic        step_btn = 1'b0;
    logic        mode_sw = 1'b0;
    logic        endProgram = 1'b0;
    logic [4:0]  cs;
    logic        cpu_en, running, halted;
    logic [15:0] cycle_count, instr_count;
    logic        cpu_en4, running4, halted4;
    logic [3:0]  cycle_count4, instr_count4;
    logic        cs_rst = 1'b1;
    int          ilen = 4;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;

    always #5 CLK = ~CLK;

    run_step_ctrl #(.DEBOUNCE_CYCLES(DB), .FETCH_STATE(5'd0), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .run_btn(run_btn), .step_btn(step_btn), .mode_sw(mode_sw),
        .CurrentState(cs), .endProgram(endProgram), .cpu_en(cpu_en), .running(running),
        .halted(halted), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    run_step_ctrl #(.DEBOUNCE_CYCLES(DB), .FETCH_STATE(5'd0), .CNT_W(4)) dut_w4 (
        .CLK(CLK), .RESET(RESET), .run_btn(run_btn), .step_btn(step_btn), .mode_sw(mode_sw),
        .CurrentState(cs), .endProgram(endProgram), .cpu_en(cpu_en4), .running(running4),
        .halted(halted4), .cycle_count(cycle_count4), .instr_count(instr_count4)
    );

    // Stand-in control unit: instructions of ilen states, advancing only when enabled
    always @(posedge CLK) begin
        if (cs_rst) cs <= 5'd0;
        else if (cpu_en) cs <= (int'(cs) >= ilen - 1) ? 5'd0 : cs + 5'd1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a press is accepted once the last DB synchronised samples all differ from the held level
    int m_st, m_cyc, m_ins;
    bit m_sp, m_lf, m_run, m_halt;
    bit hq[2][$];
    bit lvl[2];

    task automatic deb(input int b, input bit raw, output bit p);
        bit all_new = 1'b1;
        p = 1'b0;
        for (int i = 0; i < DB; i++) if (hq[b][i] == lvl[b]) all_new = 1'b0;
        if (all_new) begin
            lvl[b] = !lvl[b];
            p = lvl[b];
        end
        hq[b].push_back(raw);
        void'(hq[b].pop_front());
    endtask

    always @(negedge CLK) begin : model
        bit en, bnd, rp, sp;
        bnd = (cs == 5'd0);
        en = 1'b0;
        if (!RESET) begin
            if (m_st == M_RUN) en = !endProgram && !(m_sp && bnd);
            else if (m_st == M_STEP) en = !endProgram && !(m_lf && bnd);
        end
        if (chk_en) begin
            chk("cpu_en", cpu_en, en);
            chk("running", running, m_run);
            chk("halted", halted, m_halt);
            chk("cycle_count", cycle_count, m_cyc);
            chk("instr_count", instr_count, m_ins);
            chk("cpu_en_w4", cpu_en4, en);
            chk("cycle_count_w4", cycle_count4, (m_cyc > 15) ? 15 : m_cyc);
            chk("instr_count_w4", instr_count4, (m_ins > 15) ? 15 : m_ins);
        end
        if (RESET) begin
            m_st = M_IDLE; m_cyc = 0; m_ins = 0;
            m_sp = 0; m_lf = 0; m_run = 0; m_halt = 0;
            for (int b = 0; b < 2; b++) begin
                hq[b].delete();
                for (int i = 0; i <= DB; i++) hq[b].push_back(1'b0);
                lvl[b] = 1'b0;
            end
        end else begin
            deb(0, run_btn, rp);
            deb(1, step_btn, sp);
            if (en) begin
                if (m_cyc < 65535) m_cyc++;
                if (bnd && m_ins < 65535) m_ins++;
            end
            m_run  = (m_st == M_RUN);
            m_halt = (m_st == M_HALT);
            case (m_st)
                M_IDLE: begin
                    if (sp) begin m_st = M_STEP; m_lf = 0; end
                    else if (rp && mode_sw) m_st = M_RUN;
                end
                M_RUN: begin
                    if (endProgram) begin m_st = M_HALT; m_sp = 0; end
                    else if (m_sp && bnd) begin m_st = M_IDLE; m_sp = 0; end
                    else if (rp || !mode_sw) m_sp = 1;
                end
                M_STEP: begin
                    if (endProgram) m_st = M_HALT;
                    else if (m_lf && bnd) m_st = M_IDLE;
                    else if (en) m_lf = 1;
                end
                default: m_st = M_HALT;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1; cs_rst = 1'b1;
        tick(1);
        RESET = 1'b0; cs_rst = 1'b0;
    endtask

    task automatic press(input bit r, input bit s, input int hold);
        run_btn = r; step_btn = s;
        tick(hold);
        run_btn = 1'b0; step_btn = 1'b0;
    endtask

    typedef struct {
        int kind;     // 0 step, 1 run, 2 both in the same cycle
        bit mode;
        int len;
        int exp_cyc;
        int exp_ins;
        bit exp_run_seen;
    } vec_t;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tbl[5];
        int   lat, en_cnt, guard;
        bit   seen;
        int   rhold, shold;

        tbl[0] = '{0, 1'b1, 4, 4, 1, 1'b0};
        tbl[1] = '{0, 1'b0, 3, 3, 1, 1'b0};
        tbl[2] = '{0, 1'b1, 1, 1, 1, 1'b0};
        tbl[3] = '{1, 1'b0, 4, 0, 0, 1'b0};
        tbl[4] = '{2, 1'b1, 4, 4, 1, 1'b0};

        tick(3);
        RESET = 1'b0; cs_rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_running", running, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_instr", instr_count, 0);

        // Bouncy run press: only the final stable level may start RUN
        mode_sw = 1'b1; ilen = 4;
        for (int i = 0; i < 10; i++) begin
            run_btn = (i % 2 == 0);
            tick(3);
        end
        run_btn = 1'b1;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            if (running && lat < 0) lat = c;
        end
        chk("run_latency", lat, DB + 3);
        chk("run_held", running, 1);
        run_btn = 1'b0;
        tick(DB + 4);

        // Pause pressed mid-instruction stops only at the next fetch
        guard = 0;
        while (cs != 5'd2 && guard < 10) begin tick(1); guard++; end
        chk("pause_sync_timeout", guard < 10, 1);
        press(1'b1, 1'b0, DB + 6);
        guard = 0;
        while (running && guard < 30) begin tick(1); guard++; end
        chk("pause_timeout", guard < 30, 1);
        chk("pause_cs", cs, 0);
        chk("pause_cpu_en", cpu_en, 0);
        chk("pause_whole_instr", cycle_count % 4, 0);
        tick(DB + 4);

        // Table: single button actions from IDLE after a fresh reset
        foreach (tbl[k]) begin
            ilen = tbl[k].len; mode_sw = tbl[k].mode;
            do_reset();
            en_cnt = 0; seen = 1'b0;
            for (int c = 0; c < 2 * DB + 20; c++) begin
                run_btn  = (c < DB + 4) && (tbl[k].kind != 0);
                step_btn = (c < DB + 4) && (tbl[k].kind != 1);
                tick(1);
                en_cnt += int'(cpu_en);
                seen |= running;
            end
            chk($sformatf("vec%0d_cycles", k), cycle_count, tbl[k].exp_cyc);
            chk($sformatf("vec%0d_instrs", k), instr_count, tbl[k].exp_ins);
            chk($sformatf("vec%0d_en_cycles", k), en_cnt, tbl[k].exp_cyc);
            chk($sformatf("vec%0d_run_seen", k), seen, tbl[k].exp_run_seen);
            chk($sformatf("vec%0d_idle_en", k), cpu_en, 0);
        end

        // endProgram in RUN halts immediately and ignores buttons
        ilen = 4; mode_sw = 1'b1;
        do_reset();
        press(1'b1, 1'b0, DB + 4);
        guard = 0;
        while (cs != 5'd1 && guard < 10) begin tick(1); guard++; end
        chk("halt_sync_timeout", guard < 10, 1);
        endProgram = 1'b1;
        #1;
        chk("halt_en_same_cycle", cpu_en, 0);
        tick(1);
        endProgram = 1'b0;
        tick(1);
        chk("halted", halted, 1);
        press(1'b1, 1'b1, DB + 4);
        tick(DB + 4);
        chk("halt_sticky", halted, 1);
        chk("halt_no_run", running, 0);
        chk("halt_no_en", cpu_en, 0);
        do_reset();
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_cycle", cycle_count, 0);
        chk("halt_rst_instr", instr_count, 0);

        // Reset mid-run at cycle_count 500; narrow instance must have saturated
        press(1'b1, 1'b0, DB + 4);
        guard = 0;
        while (cycle_count != 16'd500 && guard < 700) begin tick(1); guard++; end
        chk("c500_timeout", guard < 700, 1);
        chk("w4_cycle_sat", cycle_count4, 15);
        chk("w4_instr_sat", instr_count4, 15);
        RESET = 1'b1; cs_rst = 1'b1;
        #1;
        chk("rst_cycle_en", cpu_en, 0);
        tick(1);
        RESET = 1'b0; cs_rst = 1'b0;
        chk("mid_rst_en", cpu_en, 0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_cycle", cycle_count, 0);
        chk("mid_rst_instr", instr_count, 0);

        // Random buttons, mode, endProgram and resets against the model
        rhold = 0; shold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (rhold == 0) begin run_btn = 1'($urandom_range(0, 1)); rhold = $urandom_range(1, 40); end
            if (shold == 0) begin step_btn = 1'($urandom_range(0, 1)); shold = $urandom_range(1, 40); end
            rhold--; shold--;
            if ($urandom_range(0, 99) == 0) mode_sw = ($urandom_range(0, 3) != 0);
            endProgram = ($urandom_range(0, 299) == 0);
            RESET = ($urandom_range(0, 599) == 0);
            if (RESET) ilen = $urandom_range(1, 5);
            cs_rst = RESET;
            tick(1);
        end
        RESET = 1'b0; cs_rst = 1'b0; endProgram = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
